// File: rtl/hilo_md_unit.sv
// hilo_md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Sits beside the ALU in E; busy feeds the hazard unit, hi/lo feed mfhi/mflo.
// The result is formed combinationally from the latched operands and committed
// after a fixed, parameterised number of cycles.
module hilo_md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic [31:0]        r_a, r_b;
  logic               r_done;
  logic [31:0]        r_hi, r_lo;

  logic               w_launch, w_commit, w_mt_hi, w_mt_lo;
  logic [63:0]        w_prod_s, w_prod_u;
  logic               w_a_neg, w_b_neg, w_div0;
  logic [31:0]        w_a_mag, w_b_mag, w_b_div, w_q_mag, w_r_mag, w_q, w_r;

  // Products: both operands widened to 64 bits so the low 64 bits are exact.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow corner,
  // whose magnitude quotient 0x80000000 re-signs to itself.
  assign w_a_neg = (r_op == OP_DIV) & r_a[31];
  assign w_b_neg = (r_op == OP_DIV) & r_b[31];
  assign w_a_mag = w_a_neg ? (32'd0 - r_a) : r_a;
  assign w_b_mag = w_b_neg ? (32'd0 - r_b) : r_b;
  assign w_div0  = (r_b == 32'd0);
  // Divisor forced to 1 on divide-by-zero so the datapath never sees /0.
  assign w_b_div = w_div0 ? 32'd1 : w_b_mag;
  assign w_q_mag = w_a_mag / w_b_div;
  assign w_r_mag = w_a_mag % w_b_div;
  assign w_q     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r     = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  // Next-state / control decode; start is only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    w_mt_hi     = 1'b0;
    w_mt_lo     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!op[2]) begin
            w_state_nxt = S_RUN;
            w_launch    = 1'b1;
          end else if (op[1:0] == 2'd0) begin
            w_mt_hi = 1'b1;
          end else if (op[1:0] == 2'd1) begin
            w_mt_lo = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_commit    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand latch and cycle countdown; done pulses the cycle after commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_launch) begin
        r_op  <= op[1:0];
        r_a   <= in1;
        r_b   <= in2;
        r_cnt <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // HI/LO: commit of mult/div result, or direct mthi/mtlo write from IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      case (r_op)
        OP_MULT:  {r_hi, r_lo} <= w_prod_s;
        OP_MULTU: {r_hi, r_lo} <= w_prod_u;
        default: begin
          // Divide by zero leaves HI/LO untouched.
          if (!w_div0) begin
            r_hi <= w_r;
            r_lo <= w_q;
          end
        end
      endcase
    end else begin
      if (w_mt_hi) r_hi <= in1;
      if (w_mt_lo) r_lo <= in1;
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Scoreboard bench for hilo_md_unit: stimulus pushes expected {hi,lo} per
// mult/div; a forked monitor pops and compares on every done pulse.
module tb_hilo_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] in1 = '0, in2 = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  hilo_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] expq[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        check("pending_on_done", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("res_hi", hi, e[63:32]);
          check("res_lo", lo, e[31:0]);
        end
      end
    end
  endtask

  // Issue one mult/div, measure busy length, check HI/LO held during RUN.
  // inj: drive a stray mult start at cycle 3 of RUN (must be ignored).
  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int n, input bit inj);
    int cnt;
    @(negedge clk);
    start = 1'b1; op = o; in1 = a; in2 = b;
    expq.push_back({eh, el});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in1 = ~a; in2 = ~b;
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      check("hi_held", hi, m_hi);
      check("lo_held", lo, m_lo);
      if (inj && cnt == 3) begin
        start = 1'b1; op = 3'd0; in1 = 32'h3; in2 = 32'h5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 32'(cnt), 32'(n));
    m_hi = eh; m_lo = el;
    for (int i = 0; i < 5 && expq.size() != 0; i++) @(negedge clk);
    check("done_seen", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;

    // mult / multu
    run_md(3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b0);
    run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, 1'b0);
    run_md(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5, 1'b0);
    // div / divu, remainder takes the dividend's sign
    run_md(3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
    run_md(3'd3, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10, 1'b0);
    run_md(3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 1'b0);

    // mthi then mtlo on back-to-back edges
    @(negedge clk);
    start = 1'b1; op = 3'd4; in1 = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", 32'(busy), 32'd0);
    op = 3'd5; in1 = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_busy", 32'(busy), 32'd0);
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

    // divu by zero: full latency, HI/LO unchanged, done still pulses
    run_md(3'd3, 32'h00000055, 32'd0, m_hi, m_lo, 10, 1'b0);

    // op 6/7: no effect
    @(negedge clk);
    start = 1'b1; op = 3'd6; in1 = 32'hFFFF0000;
    @(negedge clk);
    op = 3'd7;
    check("nop_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("nop_busy2", 32'(busy), 32'd0);
    check("nop_hi", hi, m_hi);
    check("nop_lo", lo, m_lo);

    // stray start during RUN ignored; 0x80000000 / -1
    run_md(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b1);

    // async reset mid-RUN aborts the op (no expectation queued)
    @(negedge clk);
    start = 1'b1; op = 3'd0; in1 = 32'd5; in2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_md(3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5, 1'b0);

    repeat (8) @(negedge clk);
    check("queue_empty", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
